ysyx_23060201_mem_arbiter: RTL and testbench

Single-outstanding memory controller that shares the DPI-backed data memory between the instruction fetch unit (read-only) and the load/store unit (read/write). It arbitrates valid/ready requests with a two-way round-robin and drives the memory port for a programmable number of cycles. It emits exactly one write strobe per store, replacing the free-running memory enables, and returns read data on a per-requester response channel.

---
 rtl/ysyx_23060201_mem_arbiter_pkg.sv | 16 +
 rtl/ysyx_23060201_rr_arb2.sv | 24 ++
 rtl/ysyx_23060201_mem_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_ysyx_23060201_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060201_mem_arbiter_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter.
//   state_e   : arbiter FSM encoding (IDLE / WAIT / RESP, 2 bits)
//   OWNER_*   : requester identifiers; also the bit index of each requester
//               in the round-robin request/grant vectors
package ysyx_23060201_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

endpackage

// File: rtl/ysyx_23060201_rr_arb2.sv
// Two-way combinational round-robin arbiter.
//   req  [1:0] in  : request vector, bit OWNER_IFU / bit OWNER_LSU
//   last       in  : requester granted most recently
//   gnt  [1:0] out : one-hot grant (all zero when nobody requests)
module ysyx_23060201_rr_arb2
    import ysyx_23060201_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // On a tie the requester that was not served last wins.
            2'b11:   gnt = (last == OWNER_IFU) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/ysyx_23060201_mem_arbiter.sv
// Single-outstanding memory controller sharing one data memory between the
// instruction fetch unit (read-only) and the load/store unit (read/write).
//   clk, rst            : clock, synchronous active-high reset
//   ifu_req_* / ifu_resp_* : IFU request (valid/ready/addr) and response
//   lsu_req_* / lsu_resp_* : LSU request (valid/ready/wen/addr/wdata/wmask)
//                            and response (rdata is 0 for stores)
//   mem_r* / mem_w*     : memory port; mem_rdata is combinational from mem_raddr
// Each access is held on the memory port for MEM_LATENCY (1..15) cycles.
// A store produces exactly one mem_wen pulse, in the first WAIT cycle.
module ysyx_23060201_mem_arbiter
    import ysyx_23060201_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1,
    parameter int CNT_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0] ifu_req_addr,
    output logic                  ifu_resp_valid,
    input  logic                  ifu_resp_ready,
    output logic [DATA_WIDTH-1:0] ifu_resp_rdata,

    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic                  lsu_req_wen,
    input  logic [ADDR_WIDTH-1:0] lsu_req_addr,
    input  logic [DATA_WIDTH-1:0] lsu_req_wdata,
    input  logic [7:0]            lsu_req_wmask,
    output logic                  lsu_resp_valid,
    input  logic                  lsu_resp_ready,
    output logic [DATA_WIDTH-1:0] lsu_resp_rdata,

    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [7:0]            mem_wmask
);

    localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(MEM_LATENCY - 1);

    state_e                 state_q, state_d;
    logic                   owner_q, owner_d;
    logic                   rr_last_q, rr_last_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   wen_q, wen_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [7:0]             wmask_q, wmask_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   first_q, first_d;

    logic [1:0]             gnt;

    ysyx_23060201_rr_arb2 u_rr_arb2 (
        .req  ({lsu_req_valid, ifu_req_valid}),
        .last (rr_last_q),
        .gnt  (gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWNER_IFU;
            rr_last_q <= OWNER_IFU;
            addr_q    <= '0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            addr_q    <= addr_d;
            wen_q     <= wen_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            first_q   <= first_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        rr_last_d      = rr_last_q;
        addr_d         = addr_q;
        wen_d          = wen_q;
        wdata_d        = wdata_q;
        wmask_d        = wmask_q;
        rdata_d        = rdata_q;
        cnt_d          = cnt_q;
        first_d        = first_q;

        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        ifu_resp_rdata = '0;
        lsu_resp_valid = 1'b0;
        lsu_resp_rdata = '0;
        mem_ren        = 1'b0;
        mem_raddr      = '0;
        mem_wen        = 1'b0;
        mem_waddr      = '0;
        mem_wdata      = '0;
        mem_wmask      = '0;

        case (state_q)
            ST_IDLE: begin
                // Ready follows the grant, so ready implies valid and any
                // non-zero grant is a fire this cycle.
                ifu_req_ready = gnt[OWNER_IFU];
                lsu_req_ready = gnt[OWNER_LSU];
                if (gnt[OWNER_LSU]) begin
                    owner_d = OWNER_LSU;
                    addr_d  = lsu_req_addr;
                    wen_d   = lsu_req_wen;
                    wdata_d = lsu_req_wdata;
                    wmask_d = lsu_req_wmask;
                end else if (gnt[OWNER_IFU]) begin
                    owner_d = OWNER_IFU;
                    addr_d  = ifu_req_addr;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    wmask_d = '0;
                end
                if (|gnt) begin
                    rr_last_d = gnt[OWNER_LSU] ? OWNER_LSU : OWNER_IFU;
                    cnt_d     = CNT_INIT;
                    first_d   = 1'b1;
                    state_d   = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (!wen_q) begin
                    mem_ren   = 1'b1;
                    mem_raddr = addr_q;
                end else if (first_q) begin
                    // Single write strobe per store, never repeated while
                    // the access is held for the remaining latency.
                    mem_wen   = 1'b1;
                    mem_waddr = addr_q;
                    mem_wdata = wdata_q;
                    mem_wmask = wmask_q;
                end
                first_d = 1'b0;
                if (cnt_q == '0) begin
                    rdata_d = wen_q ? '0 : mem_rdata;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end

            ST_RESP: begin
                if (owner_q == OWNER_IFU) begin
                    ifu_resp_valid = 1'b1;
                    ifu_resp_rdata = rdata_q;
                    if (ifu_resp_ready) state_d = ST_IDLE;
                end else begin
                    lsu_resp_valid = 1'b1;
                    lsu_resp_rdata = rdata_q;
                    if (lsu_resp_ready) state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Registers may still hold a pre-reset access during the reset cycle;
        // keep every output quiet so the memory never sees a stray write.
        if (rst) begin
            ifu_req_ready  = 1'b0;
            lsu_req_ready  = 1'b0;
            ifu_resp_valid = 1'b0;
            ifu_resp_rdata = '0;
            lsu_resp_valid = 1'b0;
            lsu_resp_rdata = '0;
            mem_ren        = 1'b0;
            mem_raddr      = '0;
            mem_wen        = 1'b0;
            mem_waddr      = '0;
            mem_wdata      = '0;
            mem_wmask      = '0;
        end
    end

endmodule

// File: tb/tb_ysyx_23060201_mem_arbiter.sv
// Directed bench: DUT "a" uses MEM_LATENCY=3, DUT "b" uses MEM_LATENCY=1.
// Both share the same request stimulus; memory returns addr ^ 0x5EADBEEF.
module tb_ysyx_23060201_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_resp_ready;
    logic [31:0] ifu_req_addr;
    logic        lsu_req_valid, lsu_req_wen, lsu_resp_ready;
    logic [31:0] lsu_req_addr, lsu_req_wdata;
    logic [7:0]  lsu_req_wmask;

    logic        a_ifu_req_ready, a_ifu_resp_valid, a_lsu_req_ready, a_lsu_resp_valid;
    logic [31:0] a_ifu_resp_rdata, a_lsu_resp_rdata;
    logic        a_mem_ren, a_mem_wen;
    logic [31:0] a_mem_raddr, a_mem_rdata, a_mem_waddr, a_mem_wdata;
    logic [7:0]  a_mem_wmask;

    logic        b_ifu_req_ready, b_ifu_resp_valid, b_lsu_req_ready, b_lsu_resp_valid;
    logic [31:0] b_ifu_resp_rdata, b_lsu_resp_rdata;
    logic        b_mem_ren, b_mem_wen;
    logic [31:0] b_mem_raddr, b_mem_rdata, b_mem_waddr, b_mem_wdata;
    logic [7:0]  b_mem_wmask;

    always #5 clk = ~clk;

    assign a_mem_rdata = a_mem_raddr ^ 32'h5EADBEEF;
    assign b_mem_rdata = b_mem_raddr ^ 32'h5EADBEEF;

    ysyx_23060201_mem_arbiter #(.MEM_LATENCY(3)) u_dut_a (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(a_ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(a_ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_resp_rdata(a_ifu_resp_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(a_lsu_req_ready), .lsu_req_wen(lsu_req_wen),
        .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_resp_valid(a_lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_resp_rdata(a_lsu_resp_rdata),
        .mem_ren(a_mem_ren), .mem_raddr(a_mem_raddr), .mem_rdata(a_mem_rdata),
        .mem_wen(a_mem_wen), .mem_waddr(a_mem_waddr), .mem_wdata(a_mem_wdata), .mem_wmask(a_mem_wmask)
    );

    ysyx_23060201_mem_arbiter #(.MEM_LATENCY(1)) u_dut_b (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(b_ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(b_ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_resp_rdata(b_ifu_resp_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(b_lsu_req_ready), .lsu_req_wen(lsu_req_wen),
        .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_resp_valid(b_lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_resp_rdata(b_lsu_resp_rdata),
        .mem_ren(b_mem_ren), .mem_raddr(b_mem_raddr), .mem_rdata(b_mem_rdata),
        .mem_wen(b_mem_wen), .mem_waddr(b_mem_waddr), .mem_wdata(b_mem_wdata), .mem_wmask(b_mem_wmask)
    );

    int          n_cmp = 0;
    int          n_bad = 0;

    int          a_lat, b_lat, a_nren, b_nren, a_nwen, b_nwen, a_oth;
    logic [31:0] a_rd, b_rd, a_ra, a_wa, a_wd;
    logic [7:0]  a_wm;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic a_mem_any();
        return a_mem_ren | a_mem_wen | (|a_mem_raddr) | (|a_mem_waddr) | (|a_mem_wdata) | (|a_mem_wmask);
    endfunction

    function automatic logic b_mem_any();
        return b_mem_ren | b_mem_wen | (|b_mem_raddr) | (|b_mem_waddr) | (|b_mem_wdata) | (|b_mem_wmask);
    endfunction

    // Called in the accept cycle (after ready was observed). Passes the accept
    // edge, drops the requests and observes both DUTs for `budget` cycles;
    // k=1 is the first cycle after the accept edge.
    task automatic go(input bit lsu, input int budget);
        a_lat = -1; b_lat = -1; a_nren = 0; b_nren = 0; a_nwen = 0; b_nwen = 0; a_oth = 0;
        a_rd = '0; b_rd = '0; a_ra = '0; a_wa = '0; a_wd = '0; a_wm = '0;
        @(posedge clk); #1;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (a_mem_ren) begin a_nren++; a_ra = a_mem_raddr; end
            if (b_mem_ren) b_nren++;
            if (a_mem_wen) begin a_nwen++; a_wa = a_mem_waddr; a_wd = a_mem_wdata; a_wm = a_mem_wmask; end
            if (b_mem_wen) b_nwen++;
            if (lsu ? a_ifu_resp_valid : a_lsu_resp_valid) a_oth++;
            if (a_lat < 0 && (lsu ? a_lsu_resp_valid : a_ifu_resp_valid)) begin
                a_lat = k;
                a_rd  = lsu ? a_lsu_resp_rdata : a_ifu_resp_rdata;
            end
            if (b_lat < 0 && (lsu ? b_lsu_resp_valid : b_ifu_resp_valid)) begin
                b_lat = k;
                b_rd  = lsu ? b_lsu_resp_rdata : b_ifu_resp_rdata;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          cnt_rv, cnt_wen, seen_any, n_g, both;
        logic [3:0]  seq;
        int          tg[4];

        rst = 1'b1;
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000; ifu_resp_ready = 1'b1;
        lsu_req_valid = 1'b1; lsu_req_wen = 1'b1; lsu_req_addr = 32'h8000_0004;
        lsu_req_wdata = 32'h1111_2222; lsu_req_wmask = 8'hFF; lsu_resp_ready = 1'b1;

        // Reset: every output quiet even with both requesters valid.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_val("rst_ready", {a_ifu_req_ready, a_lsu_req_ready, b_ifu_req_ready, b_lsu_req_ready}, 0);
        chk_val("rst_resp", {a_ifu_resp_valid, a_lsu_resp_valid, b_ifu_resp_valid, b_lsu_resp_valid}, 0);
        chk_val("rst_mem", {a_mem_any(), b_mem_any()}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // IFU read 0x80000000 -> 0xDEADBEEF.
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000;
        @(negedge clk);
        chk_val("rd_ready", {a_ifu_req_ready, a_lsu_req_ready, b_ifu_req_ready}, 3'b101);
        go(1'b0, 8);
        chk_val("rd_lat_b", b_lat, 2);
        chk_val("rd_data_b", b_rd, 32'hDEAD_BEEF);
        chk_val("rd_ren_b", b_nren, 1);
        chk_val("rd_lat_a", a_lat, 4);
        chk_val("rd_data_a", a_rd, 32'hDEAD_BEEF);
        chk_val("rd_ren_a", a_nren, 3);
        chk_val("rd_raddr_a", a_ra, 32'h8000_0000);
        chk_val("rd_nowen", a_nwen + b_nwen, 0);
        chk_val("rd_other", a_oth, 0);

        // LSU store.
        @(posedge clk); #1;
        lsu_req_valid = 1'b1; lsu_req_wen = 1'b1; lsu_req_addr = 32'h8000_0010;
        lsu_req_wdata = 32'h1234_5678; lsu_req_wmask = 8'h0F;
        @(negedge clk);
        chk_val("st_ready", {a_ifu_req_ready, a_lsu_req_ready}, 2'b01);
        go(1'b1, 8);
        chk_val("st_lat_a", a_lat, 4);
        chk_val("st_rdata_a", a_rd, 0);
        chk_val("st_wen_a", a_nwen, 1);
        chk_val("st_wvals_a", {a_wa, a_wd, a_wm}, {32'h8000_0010, 32'h1234_5678, 8'h0F});
        chk_val("st_ren_a", a_nren, 0);
        chk_val("st_lat_b", b_lat, 2);
        chk_val("st_wen_b", b_nwen, 1);
        chk_val("st_other", a_oth, 0);

        // LSU load with response back-pressure; IFU waits meanwhile.
        @(posedge clk); #1;
        lsu_req_valid = 1'b1; lsu_req_wen = 1'b0; lsu_req_addr = 32'h8000_0020;
        lsu_resp_ready = 1'b0; ifu_resp_ready = 1'b0;
        @(negedge clk);
        chk_val("hold_acc", a_lsu_req_ready, 1);
        @(posedge clk); #1;
        lsu_req_valid = 1'b0;
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0040;
        a_lat = -1;
        for (int k = 1; k <= 10 && a_lat < 0; k++) begin
            @(negedge clk);
            if (a_lsu_resp_valid) a_lat = k;
        end
        chk_val("hold_lat", a_lat, 4);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk_val("hold_stable", {a_lsu_resp_valid, a_lsu_resp_rdata, a_ifu_req_ready, a_lsu_req_ready},
                    {1'b1, 32'h8000_0020 ^ 32'h5EADBEEF, 2'b00});
        end
        @(posedge clk); #1;
        lsu_resp_ready = 1'b1; ifu_resp_ready = 1'b1;
        @(negedge clk);
        chk_val("hs_noacc", {a_lsu_resp_valid, a_ifu_req_ready, a_lsu_req_ready}, 3'b100);
        @(negedge clk);
        chk_val("post_hs_acc", {a_lsu_resp_valid, a_ifu_req_ready}, 2'b01);
        go(1'b0, 8);
        chk_val("post_hs_lat", a_lat, 4);
        chk_val("post_hs_data", a_rd, 32'h8000_0040 ^ 32'h5EADBEEF);

        // Reset during WAIT of a store.
        @(posedge clk); #1;
        lsu_req_valid = 1'b1; lsu_req_wen = 1'b1; lsu_req_addr = 32'h8000_0030;
        lsu_req_wdata = 32'hCAFE_F00D; lsu_req_wmask = 8'h03;
        @(negedge clk);
        chk_val("ab_acc", a_lsu_req_ready, 1);
        @(posedge clk); #1;
        lsu_req_valid = 1'b0;
        @(negedge clk);
        chk_val("ab_first_wen", a_mem_wen, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk_val("ab_rst_quiet", {a_mem_any(), a_lsu_resp_valid}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cnt_rv = 0; cnt_wen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (a_lsu_resp_valid || a_ifu_resp_valid) cnt_rv++;
            if (a_mem_wen) cnt_wen++;
        end
        chk_val("ab_no_resp", cnt_rv, 0);
        chk_val("ab_no_wen", cnt_wen, 0);

        // Idle port for 20 cycles.
        seen_any = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (a_mem_any() || b_mem_any()) seen_any++;
        end
        chk_val("idle_mem", seen_any, 0);

        // Round robin with both requesters continuously valid; first tie
        // after reset goes to the LSU.
        @(posedge clk); #1;
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0060;
        lsu_req_valid = 1'b1; lsu_req_wen = 1'b0; lsu_req_addr = 32'h8000_0050;
        n_g = 0; both = 0; seq = '0;
        for (int k = 1; k <= 40 && n_g < 4; k++) begin
            @(negedge clk);
            if (a_ifu_req_ready && a_lsu_req_ready) both++;
            if (a_lsu_req_ready || a_ifu_req_ready) begin
                seq = {seq[2:0], a_lsu_req_ready};
                tg[n_g] = k;
                n_g++;
            end
        end
        chk_val("rr_count", n_g, 4);
        chk_val("rr_seq", seq, 4'b1010);
        chk_val("rr_both", both, 0);
        chk_val("rr_gap1", tg[1] - tg[0], 5);
        chk_val("rr_gap3", tg[3] - tg[2], 5);
        @(posedge clk); #1;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        repeat (10) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
